// File: rtl/mem_port_pkg.sv
// Shared types and defaults for the MDR/MAR memory port.
package mem_port_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_ADDR_W  = 9;
    localparam int DEF_TIMEOUT = 15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        FIN     = 2'd3
    } state_e;

    // True while a memory request is outstanding.
    function automatic logic is_wait(input state_e s);
        return (s == RD_WAIT) || (s == WR_WAIT);
    endfunction

endpackage

// File: rtl/reg_en.sv
// Load-enable register with asynchronous active-high clear.
module reg_en #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Hold value, replace with d when enabled.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/mdr_mem_port.sv
// MAR/MDR stage: bus loads into MAR and MDR, and single-word memory
// read/write transactions with a req/ready handshake and a wait timeout.
module mdr_mem_port
    import mem_port_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] BusMuxOut,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              Read,
    input  logic              Write,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] MDR_q,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_r, state_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    logic              err_nxt_s;
    logic              mar_en_s;
    logic              mdr_ld_bus_s;
    logic              mdr_ld_mem_s;
    logic [DATA_W-1:0] mdr_r;
    logic [ADDR_W-1:0] mar_r;
    logic              mem_req_r, mem_we_r, busy_r, done_r, err_r;

    // MAR keeps only the addressable bits; upper bus bits never reach memory.
    reg_en #(.W(ADDR_W)) u_mar (
        .clk (clk),
        .clr (clr),
        .en  (mar_en_s),
        .d   (BusMuxOut[ADDR_W-1:0]),
        .q   (mar_r)
    );

    // Next-state, timeout counter and register-load decode.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        err_nxt_s    = 1'b0;
        mar_en_s     = 1'b0;
        mdr_ld_bus_s = 1'b0;
        mdr_ld_mem_s = 1'b0;
        case (state_r)
            IDLE: begin
                mar_en_s     = MARin;
                mdr_ld_bus_s = MDRin & ~Read;
                cnt_nxt_s    = '0;
                if (MDRin & Read & Write) begin
                    err_nxt_s = 1'b1;
                end else if (MDRin & Read) begin
                    state_nxt_s = RD_WAIT;
                end else if (Write) begin
                    state_nxt_s = WR_WAIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (mem_ready) begin
                    state_nxt_s  = FIN;
                    cnt_nxt_s    = '0;
                    mdr_ld_mem_s = (state_r == RD_WAIT);
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = '0;
                    err_nxt_s   = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            FIN: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = '0;
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // State, counter and registered status outputs derived from next state.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            mem_req_r <= 1'b0;
            mem_we_r  <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            mem_req_r <= is_wait(state_nxt_s);
            mem_we_r  <= (state_nxt_s == WR_WAIT);
            busy_r    <= (state_nxt_s != IDLE);
            done_r    <= (state_nxt_s == FIN);
            err_r     <= err_nxt_s;
        end
    end

    // MDR: memory read data wins over a bus load (they never coincide).
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            mdr_r <= '0;
        end else if (mdr_ld_mem_s) begin
            mdr_r <= mem_rdata;
        end else if (mdr_ld_bus_s) begin
            mdr_r <= BusMuxOut;
        end else begin
            mdr_r <= mdr_r;
        end
    end

    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mar_r;
    assign mem_wdata = mdr_r;
    assign MDR_q     = mdr_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;

endmodule

// File: tb/tb_mdr_mem_port.sv
// Directed plus randomized bench for mdr_mem_port against a transaction-level model.
module tb_mdr_mem_port;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] BusMuxOut;
    logic        MARin, MDRin, Read, Write;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_req, mem_we, busy, done, err;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata, MDR_q;

    int checks   = 0;
    int failures = 0;

    // Model state: what MAR and MDR should hold.
    logic [8:0]  m_mar;
    logic [31:0] m_mdr;

    always #5 clk = ~clk;

    mdr_mem_port #(.DATA_W(32), .ADDR_W(9), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .clr       (clr),
        .BusMuxOut (BusMuxOut),
        .MARin     (MARin),
        .MDRin     (MDRin),
        .Read      (Read),
        .Write     (Write),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .MDR_q     (MDR_q),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic quiet_inputs();
        MARin = 1'b0; MDRin = 1'b0; Read = 1'b0; Write = 1'b0;
        mem_ready = 1'b0;
    endtask

    task automatic load_mar(input logic [31:0] v);
        BusMuxOut = v; MARin = 1'b1;
        @(negedge clk);
        MARin = 1'b0;
        m_mar = v[8:0];
        chk("mar_load_addr", 32'(mem_addr), 32'(m_mar));
        chk("mar_load_busy", 32'(busy), 32'd0);
    endtask

    // mem_ready is pulsed with junk data to show it is ignored while idle.
    task automatic load_mdr(input logic [31:0] v);
        BusMuxOut = v; MDRin = 1'b1; Read = 1'b0; Write = 1'b0;
        mem_ready = 1'b1; mem_rdata = ~v;
        @(negedge clk);
        MDRin = 1'b0; mem_ready = 1'b0;
        m_mdr = v;
        chk("mdr_load_q", MDR_q, m_mdr);
        chk("mdr_load_busy", 32'(busy), 32'd0);
        chk("mdr_load_req", 32'(mem_req), 32'd0);
    endtask

    // One transaction: lat = idle wait cycles before ready; lat >= TIMEOUT times out.
    task automatic do_txn(input logic is_wr, input int lat, input logic [31:0] rd,
                          input logic new_mar, input logic [31:0] mar_v);
        BusMuxOut = mar_v; MARin = new_mar;
        MDRin = ~is_wr; Read = ~is_wr; Write = is_wr;
        if (new_mar) m_mar = mar_v[8:0];
        @(negedge clk);
        for (int i = 0; i < TIMEOUT; i++) begin
            chk("wait_req", 32'(mem_req), 32'd1);
            chk("wait_we", 32'(mem_we), 32'(is_wr));
            chk("wait_addr", 32'(mem_addr), 32'(m_mar));
            chk("wait_busy", 32'(busy), 32'd1);
            chk("wait_done", 32'(done), 32'd0);
            chk("wait_mdr_stable", MDR_q, m_mdr);
            if (is_wr) chk("wait_wdata", mem_wdata, m_mdr);
            BusMuxOut = $urandom; MARin = 1'b1; MDRin = 1'b1;
            Read = 1'($urandom_range(0, 1)); Write = 1'($urandom_range(0, 1));
            if (i == lat) begin
                mem_ready = 1'b1; mem_rdata = rd;
            end else begin
                mem_ready = 1'b0; mem_rdata = $urandom;
            end
            @(negedge clk);
            if (i == lat) break;
        end
        if (lat < TIMEOUT) begin
            if (!is_wr) m_mdr = rd;
            chk("fin_done", 32'(done), 32'd1);
            chk("fin_err", 32'(err), 32'd0);
            chk("fin_req", 32'(mem_req), 32'd0);
            chk("fin_busy", 32'(busy), 32'd1);
            chk("fin_mdr", MDR_q, m_mdr);
            MARin = 1'b0; MDRin = 1'b0; Read = 1'b0; Write = 1'b0;
            mem_ready = 1'b1; mem_rdata = $urandom;
            @(negedge clk);
            mem_ready = 1'b0;
            chk("post_done", 32'(done), 32'd0);
            chk("post_busy", 32'(busy), 32'd0);
            chk("post_mdr", MDR_q, m_mdr);
            chk("post_addr", 32'(mem_addr), 32'(m_mar));
        end else begin
            quiet_inputs();
            chk("tmo_err", 32'(err), 32'd1);
            chk("tmo_done", 32'(done), 32'd0);
            chk("tmo_req", 32'(mem_req), 32'd0);
            chk("tmo_busy", 32'(busy), 32'd0);
            chk("tmo_mdr", MDR_q, m_mdr);
            @(negedge clk);
            chk("tmo_err_clear", 32'(err), 32'd0);
        end
    endtask

    task automatic conflict(input logic use_mar, input logic [31:0] v);
        BusMuxOut = v; MARin = use_mar; MDRin = 1'b1; Read = 1'b1; Write = 1'b1;
        @(negedge clk);
        quiet_inputs();
        if (use_mar) m_mar = v[8:0];
        chk("cfl_err", 32'(err), 32'd1);
        chk("cfl_req", 32'(mem_req), 32'd0);
        chk("cfl_busy", 32'(busy), 32'd0);
        chk("cfl_done", 32'(done), 32'd0);
        chk("cfl_mdr", MDR_q, m_mdr);
        chk("cfl_addr", 32'(mem_addr), 32'(m_mar));
        @(negedge clk);
        chk("cfl_err_clear", 32'(err), 32'd0);
        chk("cfl_req_after", 32'(mem_req), 32'd0);
    endtask

    initial begin
        clr = 1'b1; BusMuxOut = 32'd0; mem_rdata = 32'd0;
        quiet_inputs();
        m_mar = 9'd0; m_mdr = 32'd0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_mdr", MDR_q, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        clr = 1'b0;
        @(negedge clk);

        // Bus load of MDR.
        load_mdr(32'hDEAD_BEEF);

        // Read, ready on the third wait cycle.
        load_mar(32'h0000_01F0);
        do_txn(1'b0, 2, 32'h1234_5678, 1'b0, 32'd0);

        // Write, ready on the first wait cycle.
        load_mdr(32'hA5A5_A5A5);
        load_mar(32'h0000_0004);
        do_txn(1'b1, 0, 32'd0, 1'b0, 32'd0);

        // Read with ready never arriving.
        do_txn(1'b0, TIMEOUT, 32'd0, 1'b0, 32'd0);

        // Ready on the very last allowed wait cycle.
        do_txn(1'b0, TIMEOUT - 1, 32'h0BAD_F00D, 1'b0, 32'd0);

        // MAR load in the trigger cycle feeds the new transaction.
        do_txn(1'b1, 1, 32'd0, 1'b1, 32'h0000_0ABC);

        // Read&Write conflict, with and without a MAR load.
        conflict(1'b0, 32'h0000_0111);
        conflict(1'b1, 32'hFFFF_FE22);

        // Reset in the middle of a read.
        MDRin = 1'b1; Read = 1'b1; Write = 1'b0;
        @(negedge clk);
        quiet_inputs();
        chk("midrst_req_before", 32'(mem_req), 32'd1);
        @(negedge clk);
        clr = 1'b1;
        #1;
        m_mdr = 32'd0; m_mar = 9'd0;
        chk("midrst_req", 32'(mem_req), 32'd0);
        chk("midrst_mdr", MDR_q, 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_addr", 32'(mem_addr), 32'd0);
        mem_ready = 1'b1; mem_rdata = 32'h5555_AAAA;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("midrst_no_done", 32'(done), 32'd0);
        end
        clr = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        chk("midrst_release_done", 32'(done), 32'd0);
        chk("midrst_release_busy", 32'(busy), 32'd0);

        // Randomized operation mix.
        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 4))
                0: load_mar($urandom);
                1: load_mdr($urandom);
                2: do_txn(1'b0, int'($urandom_range(0, TIMEOUT)), $urandom,
                          1'($urandom_range(0, 1)), $urandom);
                3: do_txn(1'b1, int'($urandom_range(0, TIMEOUT)), $urandom,
                          1'($urandom_range(0, 1)), $urandom);
                default: conflict(1'($urandom_range(0, 1)), $urandom);
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
